// File: rtl/fb_copy_arbiter_pkg.sv
// Shared widths, FIFO depth and frame-copy FSM encoding for the frame-buffer copy arbiter.
package fb_copy_arbiter_pkg;

    localparam int unsigned FB_ADDR_W     = 8;
    localparam int unsigned FB_DATA_W     = 8;
    localparam int unsigned FB_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } frame_state_t;

endpackage

// File: rtl/fb_copy_arbiter_fifo.sv
// Synchronous FIFO holding {addr, data} frame-copy words until a blank window drains them.
module fb_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_MAX);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fb_copy_arbiter.sv
// Buffers frame-copy writes and commits them to SRAM during blank; otherwise serves VGA reads.
module fb_copy_arbiter
    import fb_copy_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W,
    parameter int unsigned DEPTH  = FB_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              copy_valid,
    input  logic [ADDR_W-1:0] copy_addr,
    input  logic [DATA_W-1:0] copy_data,
    output logic              copy_ready,
    input  logic              copy_end,
    input  logic              blank,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_data_valid,
    output logic              sram_write,
    output logic              sram_read,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              frame_done,
    output logic              err_proto
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    frame_state_t             state;
    frame_state_t             state_next;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic [ADDR_W+DATA_W-1:0] head;
    logic                     push;
    logic                     rd_pend;
    logic                     accepting;

    assign accepting  = (state == ST_IDLE) || (state == ST_COPY);
    assign copy_ready = !reset && !fifo_full && accepting;
    assign push       = copy_valid && copy_ready;

    // Writes win the single SRAM port whenever blank and data is queued; reads fill every other cycle.
    assign sram_write = blank && !fifo_empty;
    assign sram_read  = !sram_write;
    assign sram_addr  = sram_write ? head[ADDR_W+DATA_W-1:DATA_W] : vga_addr;
    assign sram_wdata = head[DATA_W-1:0];
    assign frame_done = (state == ST_DONE);

    fb_sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({copy_addr, copy_data}),
        .pop   (sram_write),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (copy_end)  state_next = ST_DRAIN;
                else if (push) state_next = ST_COPY;
            end
            ST_COPY: begin
                if (copy_end) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_count == '0) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend        <= 1'b0;
            vga_data       <= '0;
            vga_data_valid <= 1'b0;
            err_proto      <= 1'b0;
        end else begin
            rd_pend        <= sram_read;
            vga_data_valid <= rd_pend;
            if (rd_pend) vga_data <= sram_rdata;
            if (copy_valid && !accepting) err_proto <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_copy_arbiter.sv
// Self-checking bench for fb_copy_arbiter: vector table, directed corner cases, random vs reference model.
module tb_fb_copy_arbiter;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       copy_valid;
    logic [7:0] copy_addr;
    logic [7:0] copy_data;
    logic       copy_ready;
    logic       copy_end;
    logic       blank;
    logic [7:0] vga_addr;
    logic [7:0] vga_data;
    logic       vga_data_valid;
    logic       sram_write;
    logic       sram_read;
    logic [7:0] sram_addr;
    logic [7:0] sram_wdata;
    logic [7:0] sram_rdata;
    logic       frame_done;
    logic       err_proto;
    logic       mem_init;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } word_t;

    word_t      wr_log[$];
    logic [7:0] sram_mem [256];

    always #5 clk = ~clk;

    fb_copy_arbiter #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .copy_valid     (copy_valid),
        .copy_addr      (copy_addr),
        .copy_data      (copy_data),
        .copy_ready     (copy_ready),
        .copy_end       (copy_end),
        .blank          (blank),
        .vga_addr       (vga_addr),
        .vga_data       (vga_data),
        .vga_data_valid (vga_data_valid),
        .sram_write     (sram_write),
        .sram_read      (sram_read),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .frame_done     (frame_done),
        .err_proto      (err_proto)
    );

    function automatic logic [7:0] init_val(input int unsigned a);
        if (a == 32'h10)      return 8'hA5;
        else if (a == 32'h00) return 8'h3C;
        else                  return 8'(a) ^ 8'h5A;
    endfunction

    // SRAM connector model: registered read data, one cycle after sram_read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
        end else if (sram_write) begin
            sram_mem[sram_addr] <= sram_wdata;
        end
        if (sram_read) sram_rdata <= sram_mem[sram_addr];
    end

    always begin
        @(negedge clk);
        #3;
        if (!reset && sram_write) wr_log.push_back({sram_addr, sram_wdata});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rst_read"},  32'(sram_read), 1);
        chk({tag, "_rst_write"}, 32'(sram_write), 0);
        chk({tag, "_rst_ready"}, 32'(copy_ready), 0);
        chk({tag, "_rst_done"},  32'(frame_done), 0);
        chk({tag, "_rst_err"},   32'(err_proto), 0);
        chk({tag, "_rst_vvld"},  32'(vga_data_valid), 0);
        chk({tag, "_rst_vdata"}, 32'(vga_data), 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; copy_valid = 1'b0; copy_end = 1'b0; blank = 1'b0;
        copy_addr = '0; copy_data = '0; mem_init = 1'b1;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        #1 chk_reset_outputs(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] a, input logic [7:0] d);
        bit ok = 0;
        copy_valid = 1'b1; copy_addr = a; copy_data = d;
        for (int k = 0; k < 40 && !ok; k++) begin
            #1 if (copy_ready) ok = 1;
            @(negedge clk);
        end
        copy_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (wr_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (wr_log.size() < n) chk("write_timeout", 32'(wr_log.size()), 32'(n));
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            #1 if (frame_done) seen = 1;
        end
        chk(nm, 32'(seen), 1);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] a;
        logic [7:0] d;
        logic       e;
        logic       b;
        logic       x_ready;
        logic       x_wr;
        logic [7:0] x_addr;
        logic [7:0] x_wdata;
        logic       x_done;
    } vec_t;

    vec_t vecs[10];

    // Reference model state (phases merge IDLE and COPY: both accept words identically).
    localparam int P_OPEN = 0, P_DRAIN = 1, P_DONE = 2;
    word_t      q[$];
    logic [7:0] ref_mem [256];
    int         phase;
    bit         m_pend, m_vvalid, m_err;
    logic [7:0] m_pval, m_vdata;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int blank_pct;
        logic [7:0] held;

        vga_addr = 8'h10;
        vecs[0] = '{1, 8'h20, 8'h11, 0, 0, 1, 0, 8'h10, 8'h00, 0};
        vecs[1] = '{1, 8'h21, 8'h22, 0, 0, 1, 0, 8'h10, 8'h00, 0};
        vecs[2] = '{1, 8'h22, 8'h33, 1, 0, 1, 0, 8'h10, 8'h00, 0};
        vecs[3] = '{0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h10, 8'h00, 0};
        vecs[4] = '{0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h20, 8'h11, 0};
        vecs[5] = '{0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h21, 8'h22, 0};
        vecs[6] = '{0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h22, 8'h33, 0};
        vecs[7] = '{0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h10, 8'h00, 0};
        vecs[8] = '{0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h10, 8'h00, 1};
        vecs[9] = '{0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h10, 8'h00, 0};

        // Read path latency after reset.
        vga_addr = 8'h00;
        do_reset("a");
        repeat (3) @(negedge clk);
        vga_addr = 8'h10;
        #1 chk("a_read0", 32'(sram_read), 1);
        chk("a_addr0", 32'(sram_addr), 32'h10);
        @(negedge clk);
        #1 chk("a_vdata1", 32'(vga_data), 32'h3C);
        chk("a_read1", 32'(sram_read), 1);
        @(negedge clk);
        #1 chk("a_vdata2", 32'(vga_data), 32'hA5);
        chk("a_vvld2", 32'(vga_data_valid), 1);

        // Vector table: three pushes (last with copy_end), then drain in blank.
        do_reset("t");
        for (int i = 0; i < 10; i++) begin
            copy_valid = vecs[i].v; copy_addr = vecs[i].a; copy_data = vecs[i].d;
            copy_end = vecs[i].e; blank = vecs[i].b;
            #1;
            chk($sformatf("t%0d_ready", i), 32'(copy_ready), 32'(vecs[i].x_ready));
            chk($sformatf("t%0d_write", i), 32'(sram_write), 32'(vecs[i].x_wr));
            chk($sformatf("t%0d_read", i), 32'(sram_read), 32'(!vecs[i].x_wr));
            chk($sformatf("t%0d_addr", i), 32'(sram_addr), 32'(vecs[i].x_addr));
            if (vecs[i].x_wr) chk($sformatf("t%0d_wdata", i), 32'(sram_wdata), 32'(vecs[i].x_wdata));
            chk($sformatf("t%0d_done", i), 32'(frame_done), 32'(vecs[i].x_done));
            @(negedge clk);
        end
        copy_valid = 1'b0; copy_end = 1'b0; blank = 1'b0;

        // Streaming 12 words through with blank held high.
        do_reset("b");
        blank = 1'b1;
        base = wr_log.size();
        for (int i = 0; i < 12; i++) push_word(8'(8'h80 + i), 8'(8'hC0 + i));
        wait_log(base + 12, 40);
        for (int i = 0; i < 12 && base + i < wr_log.size(); i++)
            chk($sformatf("b_word%0d", i), 32'(wr_log[base + i]), {16'h0, 8'(8'h80 + i), 8'(8'hC0 + i)});
        repeat (3) @(negedge clk);
        chk("b_write_count", 32'(wr_log.size() - base), 12);

        // Fill to full with blank low, then drain.
        do_reset("f");
        base = wr_log.size();
        for (int i = 0; i < 8; i++) push_word(8'(8'h60 + i), 8'(8'hE0 + i));
        #1 chk("f_ready_full", 32'(copy_ready), 0);
        chk("f_no_writes", 32'(wr_log.size() - base), 0);
        @(negedge clk);
        blank = 1'b1;
        wait_log(base + 8, 40);
        for (int i = 0; i < 8 && base + i < wr_log.size(); i++)
            chk($sformatf("f_word%0d", i), 32'(wr_log[base + i]), {16'h0, 8'(8'h60 + i), 8'(8'hE0 + i)});
        copy_end = 1'b1;
        @(negedge clk);
        copy_end = 1'b0;
        #1 chk("f_done_early", 32'(frame_done), 0);
        wait_done("f_done", 4);

        // Blank window of two cycles in the middle of a four-word backlog.
        vga_addr = 8'h00;
        do_reset("c");
        for (int i = 0; i < 4; i++) push_word(8'(8'h30 + i), 8'(8'h40 + i));
        base = wr_log.size();
        blank = 1'b1; vga_addr = 8'h10;
        #1 chk("c_wr0", 32'(sram_write), 1);
        @(negedge clk);
        #1 chk("c_wr1", 32'(sram_write), 1);
        chk("c_vvld_w1", 32'(vga_data_valid), 1);
        held = vga_data;
        chk("c_held_val", 32'(held), 32'h3C);
        @(negedge clk);
        blank = 1'b0;
        #1 chk("c_wr2", 32'(sram_write), 0);
        chk("c_rd2", 32'(sram_read), 1);
        chk("c_vvld2", 32'(vga_data_valid), 0);
        chk("c_vhold2", 32'(vga_data), 32'(held));
        @(negedge clk);
        #1 chk("c_vvld3", 32'(vga_data_valid), 0);
        chk("c_vhold3", 32'(vga_data), 32'(held));
        @(negedge clk);
        #1 chk("c_vvld4", 32'(vga_data_valid), 1);
        chk("c_vdata4", 32'(vga_data), 32'hA5);
        repeat (2) @(negedge clk);
        chk("c_two_writes", 32'(wr_log.size() - base), 2);
        if (wr_log.size() - base >= 2) begin
            chk("c_w0", 32'(wr_log[base]), 32'h3040);
            chk("c_w1", 32'(wr_log[base + 1]), 32'h3141);
        end
        blank = 1'b1;
        wait_log(base + 4, 20);
        if (wr_log.size() - base >= 4) begin
            chk("c_w2", 32'(wr_log[base + 2]), 32'h3242);
            chk("c_w3", 32'(wr_log[base + 3]), 32'h3343);
        end
        chk("c_total", 32'(wr_log.size() - base), 4);

        // Protocol error: word presented while draining.
        do_reset("d");
        blank = 1'b1;
        base = wr_log.size();
        copy_end = 1'b1;
        #1 chk("d_ready0", 32'(copy_ready), 1);
        @(negedge clk);
        copy_end = 1'b0; copy_valid = 1'b1; copy_addr = 8'h55; copy_data = 8'h99;
        #1 chk("d_ready_drain", 32'(copy_ready), 0);
        chk("d_err0", 32'(err_proto), 0);
        chk("d_done1", 32'(frame_done), 0);
        @(negedge clk);
        copy_valid = 1'b0;
        #1 chk("d_done2", 32'(frame_done), 1);
        chk("d_err1", 32'(err_proto), 1);
        @(negedge clk);
        #1 chk("d_done3", 32'(frame_done), 0);
        chk("d_ready_idle", 32'(copy_ready), 1);
        repeat (4) @(negedge clk);
        #1 chk("d_err_sticky", 32'(err_proto), 1);
        chk("d_no_write", 32'(wr_log.size() - base), 0);

        // Asynchronous reset with words queued.
        do_reset("e");
        for (int i = 0; i < 5; i++) push_word(8'(8'h70 + i), 8'(8'h01 + i));
        #2 reset = 1'b1;
        #1 chk_reset_outputs("e_async");
        @(negedge clk);
        reset = 1'b0;
        blank = 1'b1;
        base = wr_log.size();
        #1 chk("e_ready_after", 32'(copy_ready), 1);
        chk("e_write_after", 32'(sram_write), 0);
        repeat (6) @(negedge clk);
        chk("e_no_writes", 32'(wr_log.size() - base), 0);
        chk("e_done_quiet", 32'(frame_done), 0);

        // Randomized run against the reference model.
        do_reset("r");
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        q.delete();
        phase = P_OPEN; m_pend = 0; m_vvalid = 0; m_err = 0; m_pval = '0; m_vdata = '0;
        blank_pct = 50;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int  n;
            bit  exp_ready, exp_wr;
            if (cyc % 100 == 0) blank_pct = (cyc / 100) % 3 == 0 ? 10 : ((cyc / 100) % 3 == 1 ? 50 : 90);
            copy_valid = ($urandom_range(0, 3) != 0);
            copy_addr  = 8'($urandom);
            copy_data  = 8'($urandom);
            copy_end   = ($urandom_range(0, 24) == 0);
            blank      = ($urandom_range(0, 99) < blank_pct);
            vga_addr   = 8'($urandom);
            #1;
            n = q.size();
            exp_ready = (phase == P_OPEN) && (n < DEPTH);
            exp_wr    = blank && (n > 0);
            chk("r_ready", 32'(copy_ready), 32'(exp_ready));
            chk("r_write", 32'(sram_write), 32'(exp_wr));
            chk("r_read",  32'(sram_read), 32'(!exp_wr));
            chk("r_addr",  32'(sram_addr), exp_wr ? 32'(q[0].a) : 32'(vga_addr));
            if (exp_wr) chk("r_wdata", 32'(sram_wdata), 32'(q[0].d));
            chk("r_done",  32'(frame_done), 32'(phase == P_DONE));
            chk("r_err",   32'(err_proto), 32'(m_err));
            chk("r_vvld",  32'(vga_data_valid), 32'(m_vvalid));
            chk("r_vdata", 32'(vga_data), 32'(m_vdata));

            if (exp_wr) begin
                ref_mem[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (copy_valid && exp_ready) q.push_back({copy_addr, copy_data});
            m_vvalid = m_pend;
            if (m_pend) m_vdata = m_pval;
            m_pend = !exp_wr;
            if (!exp_wr) m_pval = ref_mem[vga_addr];
            if (copy_valid && phase != P_OPEN) m_err = 1;
            case (phase)
                P_OPEN:  if (copy_end) phase = P_DRAIN;
                P_DRAIN: if (n == 0) phase = P_DONE;
                default: phase = P_OPEN;
            endcase
            @(negedge clk);
        end
        copy_valid = 1'b0; copy_end = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_copy_arbiter.md
# fb_copy_arbiter

Sits between the shared-memory frame-copy port and the SRAM connector, in front of the VGA scan-out. It buffers frame-copy writes from shared memory in a small FIFO and drains them into SRAM only during sync/blank windows. Outside those windows it gives the SRAM read port to the VGA machine, which gets registered pixel data. It also tracks each frame copy and signals when every word of that copy has been committed to SRAM.

## Interface
Parameters:
- ADDR_W, 8, SRAM/frame word address width
- DATA_W, 8, pixel word width
- DEPTH, 8, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- copy_valid  in  1  shared memory presents a frame-copy word
- copy_addr  in  ADDR_W  SRAM address of the word
- copy_data  in  DATA_W  word data
- copy_ready  out  1  word accepted this cycle when valid&ready
- copy_end  in  1  one-cycle pulse: last word of this frame copy has been presented
- blank  in  1  write window (driven as ~(h_sync & v_sync))
- vga_addr  in  ADDR_W  scan-out read address
- vga_data  out  DATA_W  registered pixel data
- vga_data_valid  out  1  vga_data updated this cycle
- sram_write  out  1  write strobe to SRAM connector
- sram_read  out  1  read strobe to SRAM connector
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after sram_read
- frame_done  out  1  one-cycle pulse: copy finished and FIFO drained
- err_proto  out  1  sticky: copy_valid seen while in DRAIN

## Operation
- Frame FSM states: IDLE, COPY, DRAIN, DONE.
  - IDLE→COPY on accepted push.
  - IDLE or COPY→DRAIN on copy_end. copy_end in the same cycle as a push is legal: the word is accepted and the FSM goes to DRAIN.
  - DRAIN→DONE when count==0.
  - DONE→IDLE unconditionally. frame_done=1 only in DONE.
- copy_ready = !full && state∈{IDLE,COPY}.
  - No push-through when full, even if a pop happens in the same cycle.
  - copy_valid in DRAIN/DONE: the word is dropped and err_proto is set. err_proto stays set until reset.
- Port selection is combinational from blank and registered FIFO state:
  - sram_write = blank && !empty. The FIFO pops in the same cycle, with sram_addr/sram_wdata taken from the head.
  - Otherwise sram_read=1 and sram_addr=vga_addr.
  - Exactly one of sram_read and sram_write is high every cycle out of reset.
- Read return: rd_pend is registered from sram_read.
  - When rd_pend=1, vga_data<=sram_rdata and vga_data_valid=1 on the next edge.
  - During write cycles vga_data holds its value.
- FIFO count width is log2(DEPTH)+1. Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
- Reset values: all registers 0; state=IDLE; vga_data=0; vga_data_valid=0; frame_done=0; err_proto=0; FIFO empty.
  - During reset the outputs are sram_read=1, sram_write=0, and copy_ready=0 while reset is held.
- Reset mid-copy discards FIFO contents. No partial-frame signalling.

## Timing
- Push accepted at edge N; the word is visible at the FIFO head in cycle N+1. The earliest sram_write for it is cycle N+1 if blank=1.
- Read issued in cycle N, sram_rdata is valid in N+1, and vga_data/vga_data_valid are updated at the end of N+1, visible in N+2. Read latency is 2 cycles.
- Last pop in cycle N while in DRAIN gives count==0 in N+1, state DONE in N+2, and frame_done high in N+2 only.
- copy_end with an empty FIFO gives DRAIN in the next cycle and frame_done two cycles after copy_end.
- blank deasserting mid-drain stops writes immediately in that cycle. The FIFO retains its contents.

## Structure
- Shared package: FB_ADDR_W, FB_DATA_W, FB_FIFO_DEPTH defaults, and the frame FSM state encoding (2 bits).
- Sub-module fb_sync_fifo: width ADDR_W+DATA_W, DEPTH entries, push/pop/full/empty/count, same clk/reset.
- Top level: FSM, port mux, rd_pend pipeline, err_proto.

## Test plan
- Reset, blank=0, vga_addr=0x10, SRAM model holds 0xA5 at 0x10 → sram_read=1 every cycle; vga_data=0xA5 with valid, two cycles after addr applied.
- blank=0, push 3 words (0x20:0x11, 0x21:0x22, 0x22:0x33), then copy_end → no writes yet. Then blank=1 → three consecutive writes in order, and frame_done pulses exactly once, 2 cycles after the last write.
- blank=1, continuous copy_valid for 12 words with DEPTH=8 → every word is written to SRAM exactly once in order. Only one word is accepted per write cycle and none are lost. With blank=0, copy_ready drops after the 8th word.
- Push 4 words, blank=1 for 2 cycles then 0 → exactly 2 writes, count=2 retained, reads resume, vga_data held during the write cycles.
- copy_end, then copy_valid while in DRAIN → copy_ready=0, word not written, err_proto=1 until reset.
- Assert reset with 5 words queued → FIFO empty, state IDLE, no further sram_write, all outputs at reset values.
